// File: rtl/sprite_compositor.sv
// N-channel sprite overlay: per-frame shadowed positions, ROM addressing, fixed priority (index 0 on top)
// and per-frame collision flags. Define SPRITE_COMPOSITOR_MIRROR_EN to enable per-sprite horizontal flip.
module sprite_compositor #(
  parameter int          N_SPRITES = 4,
  parameter int          SPR_W     = 128,
  parameter int          SPR_H     = 128,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  localparam int         AW        = $clog2(SPR_W * SPR_H)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [9:0]              col,
  input  logic [8:0]              row,
  input  logic                    disp_ena,
  input  logic [N_SPRITES-1:0]    spr_en,
  input  logic [10*N_SPRITES-1:0] spr_x,
  input  logic [9*N_SPRITES-1:0]  spr_y,
  input  logic [12*N_SPRITES-1:0] spr_color,
  input  logic [N_SPRITES-1:0]    spr_mirror,
  output logic [AW*N_SPRITES-1:0] rom_addr,
  input  logic [N_SPRITES-1:0]    rom_opaque,
  output logic [11:0]             rgb,
  output logic                    rgb_valid,
  output logic [N_SPRITES-1:0]    collision,
  output logic                    collision_upd
);

  logic [N_SPRITES-1:0] en_q, en_d;
  logic [9:0]           x_q     [N_SPRITES];
  logic [9:0]           x_d     [N_SPRITES];
  logic [8:0]           y_q     [N_SPRITES];
  logic [8:0]           y_d     [N_SPRITES];
  logic [11:0]          color_q [N_SPRITES];
  logic [11:0]          color_d [N_SPRITES];
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
  logic [N_SPRITES-1:0] mirror_q, mirror_d;
`else
  logic                 unused_mirror;
  assign unused_mirror = ^spr_mirror;
`endif

  logic [N_SPRITES-1:0] hit_q, hit_d;
  logic [AW-1:0]        addr_q [N_SPRITES];
  logic [AW-1:0]        addr_d [N_SPRITES];
  logic                 dena0_q, dena0_d;
  logic [N_SPRITES-1:0] hit_dl_q [ROM_LAT];
  logic [N_SPRITES-1:0] hit_dl_d [ROM_LAT];
  logic [ROM_LAT-1:0]   dena_dl_q, dena_dl_d;

  logic [11:0]          rgb_q, rgb_d;
  logic                 rgb_valid_q, rgb_valid_d;
  logic [N_SPRITES-1:0] coll_q, coll_d, acc_q, acc_d;
  logic                 coll_upd_q, coll_upd_d;

  // Next state for shadow latch, address stage, delay line, compositor and collision tracker.
  always_comb begin
    logic [10:0]          col_off;
    logic [9:0]           row_off;
    logic                 in_x, in_y, dena_c;
    logic [N_SPRITES-1:0] px, coll_add;
    logic [11:0]          pick;
    col_off = 11'd0;
    row_off = 10'd0;
    in_x    = 1'b0;
    in_y    = 1'b0;
    en_d    = en_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
    mirror_d = mirror_q;
`endif
    if (frame_start) begin
      en_d = spr_en;
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
      mirror_d = spr_mirror;
`endif
      for (int i = 0; i < N_SPRITES; i++) begin
        x_d[i]     = spr_x[10*i +: 10];
        y_d[i]     = spr_y[9*i +: 9];
        color_d[i] = spr_color[12*i +: 12];
      end
    end else begin
      en_d = en_q;
    end

    // Offsets are taken one bit wider than the coordinates so a sprite past the right/bottom edge clips.
    for (int i = 0; i < N_SPRITES; i++) begin
      col_off = {1'b0, col} - {1'b0, x_q[i]};
      row_off = {1'b0, row} - {1'b0, y_q[i]};
      in_x    = ({1'b0, col} >= {1'b0, x_q[i]}) && (col_off < 11'(SPR_W));
      in_y    = ({1'b0, row} >= {1'b0, y_q[i]}) && (row_off < 10'(SPR_H));
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
      col_off = mirror_q[i] ? (11'(SPR_W - 1) - col_off) : col_off;
`endif
      hit_d[i] = en_q[i] && in_x && in_y;
      if (hit_d[i]) begin
        addr_d[i] = AW'(row_off) * AW'(SPR_W) + AW'(col_off);
      end else begin
        addr_d[i] = {AW{1'b0}};
      end
    end

    dena0_d      = disp_ena;
    hit_dl_d     = hit_dl_q;
    dena_dl_d    = dena_dl_q;
    hit_dl_d[0]  = hit_q;
    dena_dl_d[0] = dena0_q;
    for (int k = 1; k < ROM_LAT; k++) begin
      hit_dl_d[k]  = hit_dl_q[k-1];
      dena_dl_d[k] = dena_dl_q[k-1];
    end

    dena_c = dena_dl_q[ROM_LAT-1];
    px     = hit_dl_q[ROM_LAT-1] & rom_opaque;
    pick   = BG_COLOR;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      pick = px[i] ? color_q[i] : pick;
    end
    rgb_d       = dena_c ? pick : 12'h000;
    rgb_valid_d = dena_c;

    // px & (px-1) is nonzero exactly when two or more sprites are opaque here.
    if (dena_c && ((px & (px - N_SPRITES'(1))) != {N_SPRITES{1'b0}})) begin
      coll_add = px;
    end else begin
      coll_add = {N_SPRITES{1'b0}};
    end
    if (frame_start) begin
      coll_d     = acc_q;
      coll_upd_d = 1'b1;
      acc_d      = coll_add;
    end else begin
      coll_d     = coll_q;
      coll_upd_d = 1'b0;
      acc_d      = acc_q | coll_add;
    end
  end

  // Register update; rst returns every flop to its idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q        <= {N_SPRITES{1'b0}};
      hit_q       <= {N_SPRITES{1'b0}};
      dena0_q     <= 1'b0;
      dena_dl_q   <= {ROM_LAT{1'b0}};
      rgb_q       <= BG_COLOR;
      rgb_valid_q <= 1'b0;
      coll_q      <= {N_SPRITES{1'b0}};
      acc_q       <= {N_SPRITES{1'b0}};
      coll_upd_q  <= 1'b0;
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
      mirror_q    <= {N_SPRITES{1'b0}};
`endif
      for (int i = 0; i < N_SPRITES; i++) begin
        x_q[i]     <= 10'd0;
        y_q[i]     <= 9'd0;
        color_q[i] <= 12'h000;
        addr_q[i]  <= {AW{1'b0}};
      end
      for (int k = 0; k < ROM_LAT; k++) begin
        hit_dl_q[k] <= {N_SPRITES{1'b0}};
      end
    end else begin
      en_q        <= en_d;
      x_q         <= x_d;
      y_q         <= y_d;
      color_q     <= color_d;
      hit_q       <= hit_d;
      addr_q      <= addr_d;
      dena0_q     <= dena0_d;
      hit_dl_q    <= hit_dl_d;
      dena_dl_q   <= dena_dl_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
      coll_q      <= coll_d;
      acc_q       <= acc_d;
      coll_upd_q  <= coll_upd_d;
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
      mirror_q    <= mirror_d;
`endif
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_addr
    assign rom_addr[AW*g +: AW] = addr_q[g];
  end

  assign rgb           = rgb_q;
  assign rgb_valid     = rgb_valid_q;
  assign collision     = coll_q;
  assign collision_upd = coll_upd_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a coordinate-level reference model.
module tb_sprite_compositor;
  localparam int          N       = 4;
  localparam int          SPR_W   = 128;
  localparam int          SPR_H   = 128;
  localparam int          ROM_LAT = 1;
  localparam logic [11:0] BG      = 12'h135;
  localparam int          AW      = $clog2(SPR_W * SPR_H);
  localparam int          DEPTH   = ROM_LAT + 1;

  logic            clk = 1'b0;
  logic            rst, frame_start, disp_ena;
  logic [9:0]      col;
  logic [8:0]      row;
  logic [N-1:0]    spr_en, spr_mirror, rom_opaque;
  logic [10*N-1:0] spr_x;
  logic [9*N-1:0]  spr_y;
  logic [12*N-1:0] spr_color;
  logic [AW*N-1:0] rom_addr;
  logic [11:0]     rgb;
  logic            rgb_valid, collision_upd;
  logic [N-1:0]    collision;

  int vectors = 0;
  int miscompares = 0;
  int rom_mode = 0;

  always #20 clk = ~clk;

  sprite_compositor #(.N_SPRITES(N), .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .col(col), .row(row), .disp_ena(disp_ena),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_color(spr_color), .spr_mirror(spr_mirror),
    .rom_addr(rom_addr), .rom_opaque(rom_opaque), .rgb(rgb), .rgb_valid(rgb_valid),
    .collision(collision), .collision_upd(collision_upd)
  );

  function automatic logic rom_bit(input int i, input int a);
    if (rom_mode == 0) return 1'b1;
    return (((a >> 2) ^ a ^ (i * 5)) % 3) != 0;
  endfunction

  // Sprite ROMs with ROM_LAT clocks of read latency.
  logic [N-1:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    for (int k = ROM_LAT - 1; k > 0; k--) rom_pipe[k] <= rom_pipe[k-1];
    for (int i = 0; i < N; i++) rom_pipe[0][i] <= rom_bit(i, int'(rom_addr[AW*i +: AW]));
  end
  assign rom_opaque = rom_pipe[ROM_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each pixel in flight carries its disp_ena and which sprites are opaque there.
  typedef struct packed { logic dena; logic [N-1:0] px; } ent_t;
  ent_t         pipe [DEPTH];
  logic [AW-1:0] m_addr [N];
  logic [11:0]  m_color [N];
  int           m_x [N];
  int           m_y [N];
  logic         m_en [N];
  logic         m_mir [N];
  logic [11:0]  e_rgb;
  logic         e_valid, e_upd;
  logic [N-1:0] e_coll, e_acc;
  bit           model_ok = 1'b0;

  always @(posedge clk) begin
    ent_t         c;
    logic [11:0]  pick;
    logic [N-1:0] add, pxn;
    int           cx, cy, off;
    logic         h;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) pipe[k] = '0;
      for (int i = 0; i < N; i++) begin
        m_addr[i] = '0; m_en[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_color[i] = 12'h000; m_mir[i] = 1'b0;
      end
      e_rgb = BG; e_valid = 1'b0; e_coll = '0; e_acc = '0; e_upd = 1'b0;
      model_ok = 1'b1;
    end else begin
      c = pipe[DEPTH-1];
      pick = BG;
      for (int i = N - 1; i >= 0; i--) if (c.px[i]) pick = m_color[i];
      e_rgb   = c.dena ? pick : 12'h000;
      e_valid = c.dena;
      add     = (c.dena && $countones(c.px) >= 2) ? c.px : '0;
      e_upd   = frame_start;
      if (frame_start) begin e_coll = e_acc; e_acc = add; end
      else e_acc = e_acc | add;
      for (int k = DEPTH - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pxn = '0;
      for (int i = 0; i < N; i++) begin
        cx  = int'(col) - m_x[i];
        cy  = int'(row) - m_y[i];
        h   = m_en[i] && cx >= 0 && cx < SPR_W && cy >= 0 && cy < SPR_H;
        off = cx;
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
        if (m_mir[i]) off = SPR_W - 1 - cx;
`endif
        m_addr[i] = h ? AW'((cy * SPR_W + off) % (SPR_W * SPR_H)) : '0;
        pxn[i]    = h && rom_bit(i, int'(m_addr[i]));
      end
      pipe[0].dena = disp_ena;
      pipe[0].px   = pxn;
      if (frame_start) begin
        for (int i = 0; i < N; i++) begin
          m_en[i] = spr_en[i]; m_x[i] = int'(spr_x[10*i +: 10]); m_y[i] = int'(spr_y[9*i +: 9]);
          m_color[i] = spr_color[12*i +: 12]; m_mir[i] = spr_mirror[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("rgb", 32'(rgb), 32'(e_rgb));
      chk("rgb_valid", 32'(rgb_valid), 32'(e_valid));
      chk("collision", 32'(collision), 32'(e_coll));
      chk("collision_upd", 32'(collision_upd), 32'(e_upd));
      for (int i = 0; i < N; i++) chk("rom_addr", 32'(rom_addr[AW*i +: AW]), 32'(m_addr[i]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pix(input int c, input int r, input logic de);
    col = 10'(c); row = 9'(r); disp_ena = de;
  endtask

  task automatic set_spr(input int i, input int x, input int y, input logic [11:0] c, input logic en, input logic mir);
    spr_x[10*i +: 10] = 10'(x); spr_y[9*i +: 9] = 9'(y); spr_color[12*i +: 12] = c;
    spr_en[i] = en; spr_mirror[i] = mir;
  endtask

  task automatic clear_spr();
    for (int i = 0; i < N; i++) set_spr(i, 0, 0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; pix(0, 0, 1'b0); tick(); frame_start = 1'b0;
  endtask

  task automatic probe(input string name, input int c, input int r, input logic [11:0] exp);
    pix(c, r, 1'b1); tick(); tick(); tick();
    chk(name, 32'(rgb), 32'(exp));
  endtask

  initial begin
    int c, r, j;
    rst = 1'b1; frame_start = 1'b0; spr_x = '0; spr_y = '0; spr_color = '0; spr_en = '0; spr_mirror = '0;
    pix(0, 0, 1'b1);
    repeat (3) tick();
    rst = 1'b0;

    // Reset state, then active video with random unlatched sprite inputs: background only.
    for (int k = 0; k < 20; k++) begin
      set_spr(k % N, $urandom_range(0, 639), $urandom_range(0, 479), 12'hFFF, 1'b1, 1'b0);
      pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1);
      tick();
    end
    chk("t1_rgb_bg", 32'(rgb), 32'(BG));
    chk("t1_valid", 32'(rgb_valid), 32'h1);
    chk("t1_coll", 32'(collision), 32'h0);

    // Single sprite addressing and latency.
    clear_spr();
    set_spr(0, 256, 176, 12'h080, 1'b1, 1'b0);
    pulse_fs();
    pix(256, 176, 1'b1); tick();
    chk("t2_addr_origin", 32'(rom_addr[AW-1:0]), 32'd0);
    pix(300, 200, 1'b1); tick();
    chk("t2_addr_inner", 32'(rom_addr[AW-1:0]), 32'd3116);
    pix(384, 176, 1'b1); tick();
    chk("t2_rgb_hit", 32'(rgb), 32'h080);
    chk("t2_addr_outside", 32'(rom_addr[AW-1:0]), 32'd0);
    tick();
    chk("t2_rgb_hit2", 32'(rgb), 32'h080);
    tick();
    chk("t2_rgb_right_of_sprite", 32'(rgb), 32'(BG));

    // Priority and collision.
    clear_spr();
    set_spr(0, 100, 100, 12'h0F0, 1'b1, 1'b0);
    set_spr(1, 100, 100, 12'hF00, 1'b1, 1'b0);
    pulse_fs();
    chk("t3_coll_before", 32'(collision), 32'h0);
    pix(100, 100, 1'b1); tick();
    pix(0, 0, 1'b0); tick(); tick();
    chk("t3_priority", 32'(rgb), 32'h0F0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("t3_coll", 32'(collision), 32'h3);
    chk("t3_upd", 32'(collision_upd), 32'h1);
    tick();
    chk("t3_upd_once", 32'(collision_upd), 32'h0);

    // Right-edge clipping with no wrap to column 0.
    clear_spr();
    set_spr(0, 600, 0, 12'hABC, 1'b1, 1'b0);
    pulse_fs();
    for (int k = 600; k < 740; k++) begin
      pix(k % 640, 10, 1'b1); tick();
    end
    probe("t4_right_edge", 639, 10, 12'hABC);
    probe("t4_col0", 0, 10, BG);
    probe("t4_col87", 87, 10, BG);

    // Mid-frame position change waits for the next frame.
    clear_spr();
    set_spr(0, 100, 200, 12'h5A5, 1'b1, 1'b0);
    pulse_fs();
    probe("t5_old_pos", 100, 240, 12'h5A5);
    set_spr(0, 200, 200, 12'h5A5, 1'b1, 1'b0);
    probe("t5_still_old", 150, 240, 12'h5A5);
    probe("t5_new_not_yet", 250, 240, BG);
    pulse_fs();
    probe("t5_new_pos", 250, 240, 12'h5A5);
    probe("t5_old_gone", 150, 240, BG);

    // Mirrored addressing.
    clear_spr();
    set_spr(0, 0, 0, 12'h00F, 1'b1, 1'b1);
    pulse_fs();
    pix(0, 0, 1'b1); tick();
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
    chk("t6_addr_00", 32'(rom_addr[AW-1:0]), 32'd127);
    pix(5, 2, 1'b1); tick();
    chk("t6_addr_52", 32'(rom_addr[AW-1:0]), 32'd378);
`else
    chk("t6_addr_00", 32'(rom_addr[AW-1:0]), 32'd0);
    pix(5, 2, 1'b1); tick();
    chk("t6_addr_52", 32'(rom_addr[AW-1:0]), 32'd261);
`endif

    // rst beats a simultaneous frame_start.
    set_spr(0, 300, 300, 12'hFFF, 1'b1, 1'b0);
    rst = 1'b1; frame_start = 1'b1; tick();
    rst = 1'b0; frame_start = 1'b0;
    probe("t7_rst_wins", 310, 310, BG);

    // Randomized run with a patterned ROM, random frames, updates and occasional resets.
    rst = 1'b1; rom_mode = 1; tick(); rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      frame_start = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0)
        set_spr($urandom_range(0, N - 1), $urandom_range(380, 700), $urandom_range(260, 500),
                12'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      j = $urandom_range(0, N - 1);
      c = int'(spr_x[10*j +: 10]) + int'($urandom_range(0, 170)) - 20;
      r = int'(spr_y[9*j +: 9]) + int'($urandom_range(0, 170)) - 20;
      if (c < 0) c = 0;
      if (c > 639) c = 639;
      if (r < 0) r = 0;
      if (r > 479) r = 479;
      pix(c, r, 1'($urandom_range(0, 7) != 0));
      tick();
    end
    rst = 1'b0; frame_start = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-logo / single-ghost VGA overlay path.
- Generates ROM read addresses for N independent sprites from the VGA pixel coordinates and per-sprite positions.
- Applies per-sprite transparency and fixed priority, and outputs one composited 12-bit RGB pixel stream.
- Positions are latched per frame so sprites never tear, and pairwise opaque-pixel collisions are reported once per frame.
- Sits between vga_controller/demo and the registered VGA pin outputs.

Parameters:
- N_SPRITES, 4, number of sprite channels (1..8).
- SPR_W, 128, sprite width in pixels (power of 2).
- SPR_H, 128, sprite height in pixels.
- ROM_LAT, 1, sprite ROM read latency in clocks (1..3).
- BG_COLOR, 12'h000, RGB444 value output where no opaque sprite is present.

Ports:
- clk, in, 1, pixel clock (25 MHz).
- rst, in, 1, synchronous active-high reset.
- frame_start, in, 1, one-cycle pulse at the first pixel of a frame.
- col, in, 10, pixel column 0..639.
- row, in, 9, pixel row 0..479.
- disp_ena, in, 1, active-video flag aligned with col/row.
- spr_en, in, N_SPRITES, per-sprite enable.
- spr_x, in, 10*N_SPRITES, sprite left edge; sprite i uses bits [10i+9:10i].
- spr_y, in, 9*N_SPRITES, sprite top edge.
- spr_color, in, 12*N_SPRITES, RGB444 colour of each sprite's opaque pixels.
- spr_mirror, in, N_SPRITES, horizontal flip (see Optional Feature).
- rom_addr, out, AW*N_SPRITES, per-sprite ROM address; AW = clog2(SPR_W*SPR_H).
- rom_opaque, in, N_SPRITES, per-sprite ROM data reduced to one bit (nonzero = opaque), valid ROM_LAT clocks after rom_addr.
- rgb, out, 12, composited pixel {R,G,B}.
- rgb_valid, out, 1, delayed disp_ena aligned with rgb.
- collision, out, N_SPRITES, bit i = sprite i overlapped another opaque sprite during the previous frame.
- collision_upd, out, 1, one-cycle pulse when collision is updated.

Behaviour:
- Reset (rst=1 at a clk edge):
  - rgb=BG_COLOR, rgb_valid=0, rom_addr=0, collision=0, collision_upd=0.
  - Latched positions, enables, colours and mirror bits = 0.
  - Pipeline valid bits and the collision accumulator are cleared.
- Shadow latch:
  - On frame_start, copy spr_en/spr_x/spr_y/spr_color/spr_mirror into shadow registers; all address and compositing logic uses only the shadow copies.
  - Changes mid-frame take effect at the next frame_start.
  - The first frame after reset renders no sprites until the first frame_start.
- Stage 0 (registered, +1 clk):
  - Per sprite i, hit_i = shadow_en_i and col >= x_i and col < x_i+SPR_W and row >= y_i and row < y_i+SPR_H.
  - Compare in 11-bit (col) and 10-bit (row) unsigned; no wrap. A sprite partially beyond 639/479 is clipped.
  - rom_addr_i = (row-y_i)*SPR_W + (col-x_i), truncated to AW bits.
  - When hit_i=0, rom_addr_i holds 0.
  - hit vector and disp_ena enter a delay line.
- Stage 1..ROM_LAT:
  - hit/disp_ena delayed ROM_LAT clocks so they align with rom_opaque.
- Compose (registered, +1 clk):
  - px_i = hit_i and rom_opaque_i.
  - rgb = spr_color of the lowest-index i with px_i=1; otherwise BG_COLOR.
  - When the delayed disp_ena=0, rgb=12'h000.
  - rgb_valid = delayed disp_ena.
- Latency: col/row/disp_ena at cycle t produce rgb/rgb_valid at cycle t+ROM_LAT+2, constant.
- Collision:
  - When popcount(px) >= 2 and the delayed disp_ena=1, OR px into the accumulator.
  - On frame_start, collision <= accumulator, collision_upd pulses 1 clk, and the accumulator clears.
  - A hit coinciding with frame_start lands in the new frame's accumulator.
- Simultaneous rst and frame_start: rst wins; nothing is latched.
- Reset mid-frame: the pipeline flushes; rgb_valid stays 0 until fresh disp_ena propagates.

Optional Feature:
- Macro: SPRITE_COMPOSITOR_MIRROR_EN.
- Defined: when shadow_mirror_i=1, column offset = SPR_W-1-(col-x_i).
- Undefined: spr_mirror is ignored, the mirror shadow registers are not built, and addressing is always unmirrored.

Test Plan:
1. rst held 3 clks, then released with disp_ena=1 and no frame_start -> rgb=BG_COLOR, collision=0 at every sample.
2. ROM_LAT=1; sprite0 at (256,176), colour 12'h080, ROM all-opaque; frame_start, then col=256,row=176 -> rom_addr0=0 one clk later; rgb=12'h080 exactly 3 clks after the input; col=384 -> BG.
3. Sprites 0 and 1 both at (100,100), colours 12'h0F0 and 12'hF00, both opaque -> rgb=12'h0F0 (index 0 wins); at the next frame_start collision=2'b11 and collision_upd pulses once.
4. Sprite at x=600 (SPR_W=128), col 600..639 -> opaque; col wraps to 0 -> BG, no false hit at col 0..87.
5. Change spr_x from 100 to 200 at row 240 mid-frame -> remainder of frame still drawn at 100; drawn at 200 after the next frame_start.
6. Macro defined, spr_mirror0=1, sprite at (0,0), col=0,row=0 -> rom_addr0=SPR_W-1=127; macro undefined -> rom_addr0=0.
